// File: rtl/square_move_collector.sv
// Snapshots the sixteen move words of one square, scans them in fixed slot order
// and streams every non-zero word out through a small FIFO over valid/ready.
module square_move_collector #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        start,
   input  logic [31:0] U_move_in,
   input  logic [31:0] D_move_in,
   input  logic [31:0] L_move_in,
   input  logic [31:0] R_move_in,
   input  logic [31:0] UL_move_in,
   input  logic [31:0] UR_move_in,
   input  logic [31:0] DL_move_in,
   input  logic [31:0] DR_move_in,
   input  logic [31:0] UUL_move_in,
   input  logic [31:0] UUR_move_in,
   input  logic [31:0] LLU_move_in,
   input  logic [31:0] RRU_move_in,
   input  logic [31:0] DDL_move_in,
   input  logic [31:0] DDR_move_in,
   input  logic [31:0] LLD_move_in,
   input  logic [31:0] RRD_move_in,
   output logic [31:0] move_out,
   output logic        move_valid,
   input  logic        move_ready,
   output logic        busy,
   output logic        done,
   output logic [4:0]  move_count,
   output logic [1:0]  state_o
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t        state_q;
   logic [31:0]   snap_q [16];
   logic [3:0]    idx_q;
   logic [31:0]   fifo_q [FIFO_DEPTH];
   logic [AW-1:0] rd_q;
   logic [AW-1:0] wr_q;
   logic [CW-1:0] occ_q;
   logic [CW-1:0] occ_d;
   logic [4:0]    cnt_q;
   logic          done_q;

   logic [31:0]   in_w [16];
   logic [31:0]   slot_w;
   logic          full;
   logic          push;
   logic          pop;

   assign in_w[0]  = U_move_in;
   assign in_w[1]  = D_move_in;
   assign in_w[2]  = L_move_in;
   assign in_w[3]  = R_move_in;
   assign in_w[4]  = UL_move_in;
   assign in_w[5]  = UR_move_in;
   assign in_w[6]  = DL_move_in;
   assign in_w[7]  = DR_move_in;
   assign in_w[8]  = UUL_move_in;
   assign in_w[9]  = UUR_move_in;
   assign in_w[10] = LLU_move_in;
   assign in_w[11] = RRU_move_in;
   assign in_w[12] = DDL_move_in;
   assign in_w[13] = DDR_move_in;
   assign in_w[14] = LLD_move_in;
   assign in_w[15] = RRD_move_in;

   // Handshake: a word transfers on any rising edge where move_valid && move_ready;
   // move_out stays put while move_valid is high and move_ready is low.
   always_comb begin
      slot_w = snap_q[idx_q];
      full   = (occ_q == CW'(FIFO_DEPTH));
      pop    = move_valid && move_ready;
      push   = (state_q == S_SCAN) && (slot_w != 32'd0) && !full;
      occ_d  = occ_q + CW'(push) - CW'(pop);
   end

   assign move_valid = (occ_q != '0);
   assign move_out   = move_valid ? fifo_q[rd_q] : 32'd0;
   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign move_count = cnt_q;
   assign state_o    = state_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= S_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 5'd0;
         done_q  <= 1'b0;
         rd_q    <= '0;
         wr_q    <= '0;
         occ_q   <= '0;
         for (int i = 0; i < 16; i++) snap_q[i] <= 32'd0;
      end else begin
         done_q <= 1'b0;
         occ_q  <= occ_d;
         if (push) begin
            fifo_q[wr_q] <= slot_w;
            wr_q         <= wr_q + 1'b1;
            cnt_q        <= cnt_q + 5'd1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  snap_q  <= in_w;
                  idx_q   <= 4'd0;
                  cnt_q   <= 5'd0;
                  state_q <= S_SCAN;
               end
            end
            S_SCAN: begin
               // A non-zero word facing a full FIFO holds the index (stall).
               if ((slot_w == 32'd0) || !full) begin
                  idx_q <= idx_q + 4'd1;
                  if (idx_q == 4'd15) state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (occ_q == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/square_move_collector.md
# square_move_collector

Collects the sixteen 32-bit move words one `square` produces (eight sliding directions, eight knight jumps) and delivers them as a serial stream to the search engine. It sits between a square's `*_move_out` ports and the move-list consumer. On `start` it snapshots all sixteen words, scans them in fixed order, and pushes every non-zero word into an internal FIFO. The FIFO drains over a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 8: move FIFO entries. Must be a power of two, ≥2.
- `clk`  in  1: clock, rising edge.
- `clear`  in  1: synchronous active-high reset.
- `start`  in  1: snapshot inputs and begin a scan. Sampled only in IDLE.
- `U_move_in, D_move_in, L_move_in, R_move_in, UL_move_in, UR_move_in, DL_move_in, DR_move_in`  in  32 each: sliding move words from the square. 32'd0 means no move.
- `UUL_move_in, UUR_move_in, LLU_move_in, RRU_move_in, DDL_move_in, DDR_move_in, LLD_move_in, RRD_move_in`  in  32 each: knight move words. 32'd0 means no move.
- `move_out`  out  32: FIFO head word.
- `move_valid`  out  1: FIFO not empty.
- `move_ready`  in  1: consumer accepts `move_out` this cycle.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse when a scan completes and the FIFO is empty.
- `move_count`  out  5: number of moves pushed in the current or last scan (0..16).

## Operation
- States:
  - IDLE: `start`=1 latches all 16 inputs into a snapshot, sets scan index to 0, clears `move_count`, and goes to SCAN.
  - SCAN: one slot is evaluated per cycle, in index order U(0), D, L, R, UL, UR, DL, DR, UUL, UUR, LLU, RRU, DDL, DDR, LLD, RRD(15).
    - Slot word = 0: skip, index+1.
    - Slot word ≠ 0 and FIFO not full: push the word, `move_count`+1, index+1.
    - Slot word ≠ 0 and FIFO full: stall. Index holds and nothing is pushed.
    - When slot 15 is consumed (skipped or pushed), go to DRAIN.
  - DRAIN: when the FIFO is empty, pulse `done` next cycle and go to IDLE.
- "Full" is the registered occupancy == FIFO_DEPTH, evaluated before this cycle's pop. There is no push-through-pop bypass when full.
- Pop occurs when `move_valid` && `move_ready`, in any state. Push and pop in the same cycle are allowed when the FIFO is not full. Occupancy is then unchanged.
- FIFO is strict first-in first-out. `move_out` is don't-care when `move_valid`=0 but must be stable while `move_valid`=1 and `move_ready`=0.
- `start` outside IDLE is ignored. Input changes after the snapshot have no effect on the current scan.
- `move_count` holds its value after `done` until the next accepted `start`.
- `clear` takes priority over everything. It forces IDLE, empties the FIFO, discards the snapshot, and zeroes the index and `move_count`. Mid-scan `clear` drops all buffered moves.

## Timing
- Reset values: `move_valid`=0, `busy`=0, `done`=0, `move_count`=0, `move_out`=0.
- Edge numbering: E0 is the edge that samples `start`.
- `busy`=1 from the cycle after E0.
- Slot k is evaluated at the earliest at E(1+k). Each stall cycle delays all later slots by one.
- A word pushed at edge En raises `move_valid` in the cycle after En (one-cycle latency).
- Unstalled scan: SCAN occupies E1..E16 and DRAIN is entered after E16.
- `done` is registered:
  - It is high for exactly one cycle following the DRAIN edge that observes an empty FIFO.
  - `busy` falls in that same cycle.
  - A new `start` is accepted in that same cycle.
- All-zero inputs: `done` is high in the cycle after E17.

## Test plan
- All sixteen inputs 0, `start` pulse:
  - `move_valid` never asserts.
  - `done` is high exactly in the cycle after E17.
  - `move_count`=0.
- U=32'h0000_0101, UR=32'h0000_0202, RRD=32'h0000_0303, others 0, `move_ready`=1:
  - Stream is 0101, 0202, 0303 in that order.
  - `move_count`=3, then one `done` pulse.
- All sixteen inputs non-zero (value = slot index + 1), FIFO_DEPTH=8, `move_ready`=0 for 20 cycles, then 1:
  - Occupancy saturates at 8 and the scan stalls at slot 8.
  - All 16 words are delivered in order 1..16.
  - `move_count`=16.
- Backpressure stability: `move_ready` toggling every cycle while the scan runs:
  - `move_out` holds whenever `move_ready`=0.
  - No word is lost or duplicated.
- `start` re-asserted mid-scan and inputs changed after E0:
  - Both are ignored.
  - Output matches the E0 snapshot.
- `clear` asserted at E5 with 3 words buffered:
  - Next cycle `move_valid`=0, `busy`=0, `move_count`=0.
  - A subsequent `start` scans cleanly.
